// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - decode and instruction-memory handshake bundle for fetch_stage
// FETCH_ALIGN_CHECK_EN adds instr_misaligned_o to the bundle.
interface fetch_stage_if;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_valid_i;
  logic [31:0] imem_data_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        instr_misaligned_o;

  modport master (
    input  stall_i, redirect_valid_i, redirect_pc_i, imem_ready_i, imem_valid_i, imem_data_i,
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, instr_misaligned_o
  );
  modport slave (
    output stall_i, redirect_valid_i, redirect_pc_i, imem_ready_i, imem_valid_i, imem_data_i,
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, instr_misaligned_o
  );
`else
  modport master (
    input  stall_i, redirect_valid_i, redirect_pc_i, imem_ready_i, imem_valid_i, imem_data_i,
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o
  );
  modport slave (
    output stall_i, redirect_valid_i, redirect_pc_i, imem_ready_i, imem_valid_i, imem_data_i,
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o
  );
`endif
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, in-order imem reads, instruction buffer, redirect flush
// FETCH_ALIGN_CHECK_EN enables the misaligned-redirect trap entry and instr_misaligned_o.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          FETCH_DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rsn_i,
  fetch_stage_if.master bus
);
  localparam int AW = $clog2(FETCH_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [31:0]   NOP     = 32'h0000_0013;
  localparam logic [PW-1:0] ONE     = PW'(1);
  localparam logic [PW:0]   DEPTH_W = (PW+1)'(FETCH_DEPTH);

  typedef enum logic {S_RESET = 1'b0, S_RUN = 1'b1} state_t;
  state_t state, state_next;

  logic [31:0]   fetch_pc, pc_hold, target, head_instr, head_pc;
  logic [31:0]   pc_mem   [FETCH_DEPTH];
  logic [31:0]   data_mem [FETCH_DEPTH];
  logic [PW-1:0] alloc_ptr, fill_ptr, rd_ptr, drop_cnt;
  logic [PW-1:0] outstanding, occupancy, inflight;
  logic [PW:0]   slots;
  logic          run, redirect, redirect_misaligned, req, accept;
  logic          resp_live, resp_drop, buf_valid, out_valid, pop, pop_buf;
  logic          halt, misalign_pend;

  always_ff @(posedge clk_i) begin
    if (rsn_i) state <= S_RESET;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RESET: state_next = S_RUN;
      default: state_next = S_RUN;
    endcase
  end

  always_comb begin
    run = (state == S_RUN);
  end

`ifdef FETCH_ALIGN_CHECK_EN
  assign target                 = bus.redirect_pc_i;
  assign redirect_misaligned    = redirect & (|bus.redirect_pc_i[1:0]);
  assign bus.instr_misaligned_o = misalign_pend;
`else
  assign target              = bus.redirect_pc_i & ~32'h3;
  assign redirect_misaligned = 1'b0;
`endif

  // Slots are reserved at accept time (alloc_ptr) and filled in order by live responses.
  assign outstanding = alloc_ptr - fill_ptr;
  assign occupancy   = alloc_ptr - rd_ptr;
  assign inflight    = drop_cnt + outstanding;
  assign buf_valid   = (fill_ptr != rd_ptr);
  assign out_valid   = buf_valid | misalign_pend;
  assign redirect    = run & bus.redirect_valid_i;
  assign pop         = out_valid & ~bus.stall_i & ~redirect;
  assign pop_buf     = pop & buf_valid;
  // Old-stream responses still count against capacity so drop never exceeds FETCH_DEPTH.
  assign slots       = {1'b0, occupancy} + {1'b0, drop_cnt} - {{PW{1'b0}}, pop_buf};
  assign req         = run & ~redirect & ~halt & (slots < DEPTH_W);
  assign accept      = req & bus.imem_ready_i;
  assign resp_live   = run & bus.imem_valid_i & (drop_cnt == '0) & (outstanding != '0);
  assign resp_drop   = run & bus.imem_valid_i & (drop_cnt != '0);

  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      alloc_ptr     <= '0;
      fill_ptr      <= '0;
      rd_ptr        <= '0;
      drop_cnt      <= '0;
      fetch_pc      <= RESET_PC;
      pc_hold       <= RESET_PC;
      halt          <= 1'b0;
      misalign_pend <= 1'b0;
    end else if (redirect) begin
      fetch_pc      <= target;
      alloc_ptr     <= '0;
      fill_ptr      <= '0;
      rd_ptr        <= '0;
      drop_cnt      <= (bus.imem_valid_i && inflight != '0) ? inflight - ONE : inflight;
      halt          <= redirect_misaligned;
      misalign_pend <= redirect_misaligned;
      if (out_valid) pc_hold <= head_pc;
    end else begin
      if (accept) begin
        alloc_ptr <= alloc_ptr + ONE;
        fetch_pc  <= fetch_pc + 32'd4;
      end
      if (resp_live) fill_ptr <= fill_ptr + ONE;
      if (resp_drop) drop_cnt <= drop_cnt - ONE;
      if (pop_buf)   rd_ptr   <= rd_ptr + ONE;
      if (pop)       misalign_pend <= 1'b0;
      if (out_valid) pc_hold  <= head_pc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept)    pc_mem[alloc_ptr[AW-1:0]]  <= fetch_pc;
    if (resp_live) data_mem[fill_ptr[AW-1:0]] <= bus.imem_data_i;
  end

  always_comb begin
    head_instr = NOP;
    head_pc    = pc_hold;
    if (misalign_pend) begin
      head_pc = fetch_pc;
    end else if (buf_valid) begin
      head_instr = data_mem[rd_ptr[AW-1:0]];
      head_pc    = pc_mem[rd_ptr[AW-1:0]];
    end
  end

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = fetch_pc;
  assign bus.instr_valid_o = out_valid;
  assign bus.instr_o       = head_instr;
  assign bus.pc_o          = head_pc;
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized self-checking bench for fetch_stage against a sequential-PC stream model
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk = 1'b0;
  logic rsn;
  always #5 clk = ~clk;

  fetch_stage_if bus();
  fetch_stage #(.RESET_PC(RESET_PC), .FETCH_DEPTH(2)) dut (.clk_i(clk), .rsn_i(rsn), .bus(bus));

  typedef struct {
    logic        mark;
    logic [31:0] pc;
    logic [31:0] instr;
  } obs_t;

  obs_t        obs[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc, lat, n_pass, n_total;
  logic [31:0] salt, exp_next;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_instr, s_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        s_mis;
`endif

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  // One clock: sample at #1 after the falling edge, record stream events, then present the memory response.
  task automatic step();
    obs_t o;
    #1;
    s_req   = bus.imem_req_o;
    s_addr  = bus.imem_addr_o;
    s_valid = bus.instr_valid_o;
    s_instr = bus.instr_o;
    s_pc    = bus.pc_o;
`ifdef FETCH_ALIGN_CHECK_EN
    s_mis   = bus.instr_misaligned_o;
`endif
    if (rsn) begin
      pend_addr.delete();
      pend_due.delete();
      o.mark = 1'b1; o.pc = RESET_PC; o.instr = '0;
      obs.push_back(o);
    end else begin
      if (bus.imem_req_o && bus.imem_ready_i) begin
        pend_addr.push_back(bus.imem_addr_o);
        pend_due.push_back(cyc + lat);
      end
      if (bus.redirect_valid_i) begin
        o.mark = 1'b1; o.pc = bus.redirect_pc_i & ~32'h3; o.instr = '0;
        obs.push_back(o);
      end else if (bus.instr_valid_o && !bus.stall_i) begin
        o.mark = 1'b0; o.pc = bus.pc_o; o.instr = bus.instr_o;
        obs.push_back(o);
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      bus.imem_valid_i = 1'b1;
      bus.imem_data_i  = memw(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      bus.imem_valid_i = 1'b0;
      bus.imem_data_i  = $urandom();
    end
  endtask

  task automatic do_reset();
    rsn = 1'b1;
    bus.stall_i = 1'b0;
    bus.redirect_valid_i = 1'b0;
    bus.imem_ready_i = 1'b1;
    step();
    step();
    rsn = 1'b0;
    obs.delete();
    exp_next = RESET_PC;
  endtask

  task automatic test_reset();
    lat = 1;
    rsn = 1'b1;
    bus.stall_i = 1'b0;
    bus.redirect_valid_i = 1'b0;
    bus.redirect_pc_i = '0;
    bus.imem_ready_i = 1'b1;
    bus.imem_valid_i = 1'b0;
    bus.imem_data_i = '0;
    step();
    step();
    n_total++; if (s_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", s_valid); else n_pass++;
    n_total++; if (s_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", s_req); else n_pass++;
    n_total++; if (s_instr !== NOP) $display("FAIL reset_instr: got %h expected %h", s_instr, NOP); else n_pass++;
    n_total++; if (s_pc !== RESET_PC) $display("FAIL reset_pc: got %h expected %h", s_pc, RESET_PC); else n_pass++;
    rsn = 1'b0;
    step();
    n_total++; if (s_req !== 1'b0) $display("FAIL reset_state_req: got %b expected 0", s_req); else n_pass++;
    step();
    n_total++; if (s_req !== 1'b1) $display("FAIL run_first_req: got %b expected 1", s_req); else n_pass++;
    n_total++; if (s_addr !== RESET_PC) $display("FAIL run_first_addr: got %h expected %h", s_addr, RESET_PC); else n_pass++;
    obs.delete();
    exp_next = RESET_PC;
  endtask

  task automatic test_stream();
    obs_t o;
    int first_v = -1;
    int gaps = 0;
    int nreal = 0;
    lat = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (s_valid) begin
        if (first_v < 0) first_v = i;
      end else if (first_v >= 0) begin
        gaps++;
      end
    end
    n_total++; if (first_v !== 1) $display("FAIL stream_latency: got %0d expected 1", first_v); else n_pass++;
    n_total++; if (gaps !== 0) $display("FAIL stream_gaps: got %0d expected 0", gaps); else n_pass++;
    while (obs.size() > 0) begin
      o = obs.pop_front();
      if (o.mark) exp_next = o.pc;
      else begin
        nreal++;
        n_total++; if (o.pc !== exp_next) $display("FAIL stream_pc: got %h expected %h", o.pc, exp_next); else n_pass++;
        n_total++; if (o.instr !== memw(exp_next)) $display("FAIL stream_instr: got %h expected %h", o.instr, memw(exp_next)); else n_pass++;
        exp_next += 32'd4;
      end
    end
    n_total++; if (nreal < 4) $display("FAIL stream_count: got %0d expected >=4", nreal); else n_pass++;
  endtask

  task automatic test_stall();
    obs_t o;
    logic [31:0] hold_pc, hold_instr;
    int nreal = 0;
    lat = 1;
    bus.stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) begin
        hold_pc = s_pc;
        hold_instr = s_instr;
      end else begin
        n_total++; if (s_req !== 1'b0) $display("FAIL stall_req: got %b expected 0", s_req); else n_pass++;
        n_total++; if (s_valid !== 1'b1) $display("FAIL stall_valid: got %b expected 1", s_valid); else n_pass++;
        n_total++; if (s_pc !== hold_pc) $display("FAIL stall_pc_stable: got %h expected %h", s_pc, hold_pc); else n_pass++;
        n_total++; if (s_instr !== hold_instr) $display("FAIL stall_instr_stable: got %h expected %h", s_instr, hold_instr); else n_pass++;
      end
    end
    n_total++; if (hold_pc !== exp_next) $display("FAIL stall_head_pc: got %h expected %h", hold_pc, exp_next); else n_pass++;
    bus.stall_i = 1'b0;
    for (int i = 0; i < 8; i++) step();
    while (obs.size() > 0) begin
      o = obs.pop_front();
      if (o.mark) exp_next = o.pc;
      else begin
        nreal++;
        n_total++; if (o.pc !== exp_next) $display("FAIL stall_resume_pc: got %h expected %h", o.pc, exp_next); else n_pass++;
        n_total++; if (o.instr !== memw(exp_next)) $display("FAIL stall_resume_instr: got %h expected %h", o.instr, memw(exp_next)); else n_pass++;
        exp_next += 32'd4;
      end
    end
    n_total++; if (nreal < 4) $display("FAIL stall_resume_count: got %0d expected >=4", nreal); else n_pass++;
  endtask

  task automatic test_ready_hold();
    obs_t o;
    int nreal = 0;
    do_reset();
    lat = 1;
    bus.imem_ready_i = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++; if (s_req !== 1'b1) $display("FAIL hold_req: got %b expected 1", s_req); else n_pass++;
      n_total++; if (s_addr !== RESET_PC) $display("FAIL hold_addr: got %h expected %h", s_addr, RESET_PC); else n_pass++;
    end
    bus.imem_ready_i = 1'b1;
    step();
    n_total++; if (s_addr !== RESET_PC) $display("FAIL hold_accept_addr: got %h expected %h", s_addr, RESET_PC); else n_pass++;
    step();
    n_total++; if (s_addr !== RESET_PC + 32'd4) $display("FAIL hold_next_addr: got %h expected %h", s_addr, RESET_PC + 32'd4); else n_pass++;
    for (int i = 0; i < 6; i++) step();
    while (obs.size() > 0) begin
      o = obs.pop_front();
      if (o.mark) exp_next = o.pc;
      else begin
        nreal++;
        n_total++; if (o.pc !== exp_next) $display("FAIL hold_stream_pc: got %h expected %h", o.pc, exp_next); else n_pass++;
        n_total++; if (o.instr !== memw(exp_next)) $display("FAIL hold_stream_instr: got %h expected %h", o.instr, memw(exp_next)); else n_pass++;
        exp_next += 32'd4;
      end
    end
    n_total++; if (nreal < 4) $display("FAIL hold_stream_count: got %0d expected >=4", nreal); else n_pass++;
  endtask

  task automatic test_redirect();
    obs_t o;
    int nreal = 0;
    do_reset();
    lat = 3;
    step();
    step();
    step();
    n_total++; if (s_addr !== RESET_PC + 32'd4) $display("FAIL redir_second_req_addr: got %h expected %h", s_addr, RESET_PC + 32'd4); else n_pass++;
    obs.delete();
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i = 32'h0000_0100;
    step();
    n_total++; if (s_req !== 1'b0) $display("FAIL redir_req_blocked: got %b expected 0", s_req); else n_pass++;
    bus.redirect_valid_i = 1'b0;
    for (int i = 0; i < 20; i++) step();
    n_total++;
    if (obs.size() == 0 || obs[0].mark !== 1'b1) $display("FAIL redir_old_dropped: got %0d entries expected marker first", obs.size());
    else n_pass++;
    while (obs.size() > 0) begin
      o = obs.pop_front();
      if (o.mark) exp_next = o.pc;
      else begin
        nreal++;
        n_total++; if (o.pc !== exp_next) $display("FAIL redir_pc: got %h expected %h", o.pc, exp_next); else n_pass++;
        n_total++; if (o.instr !== memw(exp_next)) $display("FAIL redir_instr: got %h expected %h", o.instr, memw(exp_next)); else n_pass++;
        exp_next += 32'd4;
      end
    end
    n_total++; if (nreal < 3) $display("FAIL redir_count: got %0d expected >=3", nreal); else n_pass++;
  endtask

  task automatic test_mid_reset();
    obs_t o;
    int nreal = 0;
    do_reset();
    lat = 1;
    for (int i = 0; i < 8; i++) step();
    rsn = 1'b1;
    step();
    rsn = 1'b0;
    step();
    n_total++; if (s_valid !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", s_valid); else n_pass++;
    n_total++; if (s_req !== 1'b0) $display("FAIL midrst_req: got %b expected 0", s_req); else n_pass++;
    for (int i = 0; i < 10; i++) step();
    while (obs.size() > 0) begin
      o = obs.pop_front();
      if (o.mark) exp_next = o.pc;
      else begin
        nreal++;
        n_total++; if (o.pc !== exp_next) $display("FAIL midrst_pc: got %h expected %h", o.pc, exp_next); else n_pass++;
        n_total++; if (o.instr !== memw(exp_next)) $display("FAIL midrst_instr: got %h expected %h", o.instr, memw(exp_next)); else n_pass++;
        exp_next += 32'd4;
      end
    end
    n_total++; if (nreal < 8) $display("FAIL midrst_count: got %0d expected >=8", nreal); else n_pass++;
  endtask

  task automatic test_random();
    obs_t o;
    int nreal = 0;
    do_reset();
    lat = 1;
    step();
    step();
    for (int i = 0; i < 400; i++) begin
      bus.stall_i = ($urandom_range(0, 3) == 0);
      bus.imem_ready_i = ($urandom_range(0, 3) != 0);
      lat = $urandom_range(1, 3);
      bus.redirect_valid_i = 1'b0;
      if (i == 20) begin
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i = 32'hFFFF_FFF8;
      end else if ($urandom_range(0, 29) == 0) begin
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i = $urandom() & 32'hFFFF_FFFC;
      end
      step();
    end
    bus.redirect_valid_i = 1'b0;
    bus.stall_i = 1'b0;
    bus.imem_ready_i = 1'b1;
    for (int i = 0; i < 15; i++) step();
    while (obs.size() > 0) begin
      o = obs.pop_front();
      if (o.mark) exp_next = o.pc;
      else begin
        nreal++;
        n_total++; if (o.pc !== exp_next) $display("FAIL rand_pc: got %h expected %h", o.pc, exp_next); else n_pass++;
        n_total++; if (o.instr !== memw(exp_next)) $display("FAIL rand_instr: got %h expected %h", o.instr, memw(exp_next)); else n_pass++;
        exp_next += 32'd4;
      end
    end
    n_total++; if (nreal < 40) $display("FAIL rand_count: got %0d expected >=40", nreal); else n_pass++;
  endtask

`ifdef FETCH_ALIGN_CHECK_EN
  task automatic test_misaligned();
    obs_t o;
    int nreal = 0;
    do_reset();
    lat = 1;
    step();
    step();
    step();
    bus.stall_i = 1'b1;
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i = 32'h0000_0102;
    step();
    bus.redirect_valid_i = 1'b0;
    step();
    n_total++; if (s_valid !== 1'b1) $display("FAIL mis_valid: got %b expected 1", s_valid); else n_pass++;
    n_total++; if (s_mis !== 1'b1) $display("FAIL mis_flag: got %b expected 1", s_mis); else n_pass++;
    n_total++; if (s_pc !== 32'h0000_0102) $display("FAIL mis_pc: got %h expected 00000102", s_pc); else n_pass++;
    n_total++; if (s_instr !== NOP) $display("FAIL mis_instr: got %h expected %h", s_instr, NOP); else n_pass++;
    n_total++; if (s_req !== 1'b0) $display("FAIL mis_req: got %b expected 0", s_req); else n_pass++;
    bus.stall_i = 1'b0;
    step();
    step();
    n_total++; if (s_valid !== 1'b0) $display("FAIL mis_popped_valid: got %b expected 0", s_valid); else n_pass++;
    n_total++; if (s_req !== 1'b0) $display("FAIL mis_halt_req: got %b expected 0", s_req); else n_pass++;
    obs.delete();
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i = 32'h0000_0200;
    step();
    bus.redirect_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) step();
    while (obs.size() > 0) begin
      o = obs.pop_front();
      if (o.mark) exp_next = o.pc;
      else begin
        nreal++;
        n_total++; if (o.pc !== exp_next) $display("FAIL mis_recover_pc: got %h expected %h", o.pc, exp_next); else n_pass++;
        n_total++; if (o.instr !== memw(exp_next)) $display("FAIL mis_recover_instr: got %h expected %h", o.instr, memw(exp_next)); else n_pass++;
        exp_next += 32'd4;
      end
    end
    n_total++; if (nreal < 3) $display("FAIL mis_recover_count: got %0d expected >=3", nreal); else n_pass++;
  endtask
`endif

  initial begin
    n_pass = 0;
    n_total = 0;
    cyc = 0;
    salt = $urandom();
    test_reset();
    test_stream();
    test_stall();
    test_ready_hold();
    test_redirect();
    test_mid_reset();
    test_random();
`ifdef FETCH_ALIGN_CHECK_EN
    test_misaligned();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
